// File: rtl/fix_to_single_pkg.sv
// Shared IEEE-754 single-precision constants and converter state encoding
// used by the fixed-to-single return path.
package fix_to_single_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_PACK = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] fp32_join(
    input logic                   sign_f,
    input logic [FP32_EXP_W-1:0]  exp_f,
    input logic [FP32_MANT_W-1:0] mant_f
  );
    return {sign_f, exp_f, mant_f};
  endfunction

endpackage

// File: rtl/fix_to_single_pack.sv
// Combinational packer: normalised magnitude plus shift count -> IEEE-754 word.
// A zero magnitude always produces +0.0.
module fix_to_single_pack
  import fix_to_single_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4,
  localparam int W          = INT_WIDTH + FRACT_WIDTH,
  localparam int CW         = $clog2(W) + 1
) (
  input  logic          sign,
  input  logic [CW-1:0] count,
  input  logic [W-1:0]  mag,
  output logic [31:0]   single
);

  // Exponent of an un-shifted word whose MSB is set.
  localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_BIAS + INT_WIDTH - 1);

  logic [FP32_EXP_W-1:0]  exp_s;
  logic [FP32_MANT_W-1:0] mant_s;

  assign exp_s = EXP_TOP - {{(FP32_EXP_W-CW){1'b0}}, count};

  // Hidden bit dropped; wide words lose their low bits (round toward zero).
  generate
    if (W - 1 >= FP32_MANT_W) begin : g_trunc
      assign mant_s = mag[W-2 -: FP32_MANT_W];
    end else begin : g_fill
      assign mant_s = {mag[W-2:0], {(FP32_MANT_W-W+1){1'b0}}};
    end
  endgenerate

  assign single = (mag == {W{1'b0}}) ? 32'h0000_0000 : fp32_join(sign, exp_s, mant_s);

endmodule

// File: rtl/fix_to_single.sv
// Iterative fixed-point (Q INT_WIDTH.FRACT_WIDTH) to IEEE-754 single converter,
// normalising one bit per cycle behind valid/ready handshakes.
module fix_to_single
  import fix_to_single_pkg::*;
#(
  parameter int  INT_WIDTH   = 12,
  parameter int  FRACT_WIDTH = 4,
  parameter bit  SIGNED      = 1'b0,
  localparam int W           = INT_WIDTH + FRACT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] fixed_point,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  single
);

  localparam int CW = $clog2(W) + 1;

  generate
    if (W < 2 || W > 32) begin : g_bad_width
      $error("fix_to_single: INT_WIDTH+FRACT_WIDTH must be within 2..32");
    end
  endgenerate

  state_t        state_r, state_s;
  logic          sign_r, sign_s;
  logic [W-1:0]  mag_r, mag_s;
  logic [CW-1:0] count_r, count_s;
  logic [31:0]   single_r, single_s;
  logic          in_ready_r, out_valid_r;
  logic          is_neg_s;
  logic [W-1:0]  abs_s;
  logic [31:0]   pack_s;

  // Two's-complement negation of the most negative value is exact in W unsigned bits.
  assign is_neg_s = (SIGNED == 1'b1) && fixed_point[W-1];
  assign abs_s    = is_neg_s ? (~fixed_point + {{(W-1){1'b0}}, 1'b1}) : fixed_point;

  fix_to_single_pack #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_pack (
    .sign   (sign_r),
    .count  (count_r),
    .mag    (mag_r),
    .single (pack_s)
  );

  // Next-state and datapath update for the capture/normalise/pack/hold sequence.
  always_comb begin
    state_s  = state_r;
    sign_s   = sign_r;
    mag_s    = mag_r;
    count_s  = count_r;
    single_s = single_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          sign_s  = is_neg_s;
          mag_s   = abs_s;
          count_s = {CW{1'b0}};
          // Zero skips normalisation; the packer turns it into +0.0.
          if (abs_s == {W{1'b0}}) begin
            state_s = S_PACK;
          end else begin
            state_s = S_NORM;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_NORM: begin
        if (mag_r[W-1]) begin
          state_s = S_PACK;
        end else begin
          mag_s   = {mag_r[W-2:0], 1'b0};
          count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_PACK: begin
        single_s = pack_s;
        state_s  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and datapath registers; handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      sign_r      <= 1'b0;
      mag_r       <= {W{1'b0}};
      count_r     <= {CW{1'b0}};
      single_r    <= 32'h0000_0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sign_r      <= sign_s;
      mag_r       <= mag_s;
      count_r     <= count_s;
      single_r    <= single_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign single    = single_r;

endmodule

// File: tb/tb_fix_to_single.sv
// Bench for fix_to_single: four parameter sets driven side by side, directed
// cases plus random words checked against an arithmetic reference model.
module tb_fix_to_single;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [31:0] fp        [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] single    [4];

  int cfg_w [4] = '{16, 16, 32, 32};
  int cfg_f [4] = '{4, 4, 0, 0};
  bit cfg_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fix_to_single u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .fixed_point(fp[0][15:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .single(single[0])
  );

  fix_to_single #(.INT_WIDTH(12), .FRACT_WIDTH(4), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .fixed_point(fp[1][15:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .single(single[1])
  );

  fix_to_single #(.INT_WIDTH(32), .FRACT_WIDTH(0), .SIGNED(1'b0)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .fixed_point(fp[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .single(single[2])
  );

  fix_to_single #(.INT_WIDTH(32), .FRACT_WIDTH(0), .SIGNED(1'b1)) u_w32s (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .fixed_point(fp[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .single(single[3])
  );

  // Value semantics: find the leading one of |v|, scale the remainder into 23 bits.
  function automatic logic [31:0] model(input logic [31:0] word, input int w, input int f,
                                        input bit sgn, output int lat);
    longint one, v, m, frac;
    int e, expv;
    logic s;
    logic [31:0] mant;
    one = 64'sd1;
    v = longint'({32'h0000_0000, word}) & ((one << w) - one);
    if (sgn && (((v >> (w - 1)) & one) == one)) v = v - (one << w);
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) begin
      lat = 1;
      return 32'h0000_0000;
    end
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    expv = 127 + e - f;
    frac = m - (one << e);
    if (e >= 23) mant = 32'(frac >> (e - 23));
    else         mant = 32'(frac << (23 - e));
    lat = (w - 1 - e) + 2;
    return {s, expv[7:0], mant[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Offer one word to instance k; return the result and edges from accept to out_valid.
  task automatic convert(input int k, input logic [31:0] word,
                         output logic [31:0] res, output int lat);
    int cyc;
    @(negedge clk);
    fp[k] = word;
    in_valid[k] = 1'b1;
    cyc = 0;
    while (!in_ready[k] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = single[k];
  endtask

  task automatic directed(input string tag, input int k, input logic [31:0] word,
                          input logic [31:0] exp_single, input int exp_lat);
    logic [31:0] res;
    int lat;
    convert(k, word, res, lat);
    check({tag, "_val"}, res, exp_single);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] res, s0, word, exp_single;
    int lat, exp_lat;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      fp[k]        = 32'h0000_0000;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_in_ready%0d", k), {31'd0, in_ready[k]}, 32'd1);
      check($sformatf("reset_out_valid%0d", k), {31'd0, out_valid[k]}, 32'd0);
      check($sformatf("reset_single%0d", k), single[k], 32'h0000_0000);
    end

    directed("one",      0, 32'h0000_0010, 32'h3F80_0000, 13);
    directed("max",      0, 32'h0000_FFFF, 32'h457F_FF00, 2);
    directed("lsb",      0, 32'h0000_0001, 32'h3D80_0000, 17);
    directed("zero",     0, 32'h0000_0000, 32'h0000_0000, 1);
    directed("neg_one",  1, 32'h0000_FFF0, 32'hBF80_0000, 13);
    directed("s_zero",   1, 32'h0000_0000, 32'h0000_0000, 1);
    directed("s_minneg", 1, 32'h0000_8000, 32'hC500_0000, 2);
    directed("w32_trunc",2, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 2);
    directed("w32_min",  3, 32'h8000_0000, 32'hCF00_0000, 2);

    // Backpressure: result and handshake signals frozen while out_ready is low.
    repeat (2) @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    exp_single = model(32'h0000_0123, 16, 4, 1'b0, exp_lat);
    convert(0, 32'h0000_0123, s0, lat);
    check("bp_val", s0, exp_single);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid[0]}, 32'd1);
      check($sformatf("bp_hold_single%0d", i), single[0], exp_single);
      check($sformatf("bp_hold_ready%0d", i), {31'd0, in_ready[0]}, 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, out_valid[0]}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_single_shot", {31'd0, out_valid[0]}, 32'd0);

    // Reset while normalising a long word.
    @(negedge clk);
    fp[0] = 32'h0000_0001;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("mid_rst_single", single[0], 32'h0000_0000);
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_result", {31'd0, out_valid[0]}, 32'd0);
    directed("after_rst", 0, 32'h0000_0010, 32'h3F80_0000, 13);

    // Random words, biased toward varied leading-zero counts.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 30; i++) begin
        word = $urandom >> $urandom_range(0, 31);
        if (cfg_w[k] == 16) word = word & 32'h0000_FFFF;
        if (i == 0) word = 32'h0000_0000;
        exp_single = model(word, cfg_w[k], cfg_f[k], cfg_s[k], exp_lat);
        convert(k, word, res, lat);
        check($sformatf("rand%0d_%0d_val(%h)", k, i, word), res, exp_single);
        check($sformatf("rand%0d_%0d_lat(%h)", k, i, word), 32'(lat), 32'(exp_lat));
      end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
